pe_array_ctrl: RTL and testbench

//  Sequencer for the 5x5 weight-stationary systolic PE array. Per job it preloads 25 weights from a

---
 rtl/pe_array_pkg.sv | 24 ++
 rtl/pe_array_ctrl_if.sv | 45 ++++
 rtl/skew_delay_line.sv | 36 +++
 rtl/pe_array_ctrl.sv | 152 +++++++++++++++
 tb/tb_pe_array_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_array_pkg.sv
// Shared constants, state encoding and helpers for the 5x5 weight-stationary
// PE array sequencer.
package pe_array_pkg;

  localparam int DEF_N          = 5;   // array dimension
  localparam int DEF_PORT_WIDTH = 8;   // operand width of data and weight lanes
  localparam int DEF_ACC_LAT    = 13;  // unskewed accept -> acc_out latency
  localparam int DEF_CNT_W      = 16;  // column counter width

  // Sequencer states, in the order a job walks through them.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLOAD  = 3'd1,
    ST_WDRAIN = 3'd2,
    ST_STREAM = 3'd3,
    ST_FLUSH  = 3'd4
  } state_t;

  // Width of a PE id (N*row+col) and of the weight-buffer address.
  function automatic int pe_id_w(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Bundle of the scheduler, weight-buffer, input-stream and array-side signals
// of the PE array sequencer. master = sequencer, slave = its environment.
interface pe_array_ctrl_if
  import pe_array_pkg::*;
#(
  parameter int PORT_WIDTH = DEF_PORT_WIDTH,
  parameter int N          = DEF_N,
  parameter int CNT_W      = DEF_CNT_W
);

  localparam int PE_W = pe_id_w(N);

  // Layer scheduler
  logic                    start;
  logic [CNT_W-1:0]        num_cols;
  logic                    busy;
  logic                    done;
  // Weight buffer
  logic                    w_rd_en;
  logic [PE_W-1:0]         w_rd_addr;
  logic [PORT_WIDTH-1:0]   w_rd_data;
  // Input vector stream
  logic                    x_valid;
  logic [N*PORT_WIDTH-1:0] x_data;
  logic                    x_ready;
  // PE array
  logic                    WorI;
  logic [PORT_WIDTH-1:0]   weight_in;
  logic [PE_W-1:0]         weight_location;
  logic [N*PORT_WIDTH-1:0] a_out;
  logic                    acc_valid;

  modport master (
    input  start, num_cols, w_rd_data, x_valid, x_data,
    output busy, done, w_rd_en, w_rd_addr, x_ready,
           WorI, weight_in, weight_location, a_out, acc_valid
  );

  modport slave (
    output start, num_cols, w_rd_data, x_valid, x_data,
    input  busy, done, w_rd_en, w_rd_addr, x_ready,
           WorI, weight_in, weight_location, a_out, acc_valid
  );

endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth register chain used to give array row k its k-cycle systolic
// skew. DEPTH=0 is a plain wire.
module skew_delay_line #(
  parameter int PORT_WIDTH = 8,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORT_WIDTH-1:0] i_d,
  output logic [PORT_WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_pass
    // Row 0 has no skew; clock and reset only matter for the chained case.
    logic w_unused;
    assign w_unused = clk ^ rst_n;
    assign o_q      = i_d;
  end else begin : g_chain
    logic [PORT_WIDTH-1:0] r_stage [DEPTH];

    // Shift the lane value one stage per cycle.
    // NOTE: this is a short register chain, not a RAM, so every stage is reset;
    // the array must see zeros on every lane straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else begin
        r_stage[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/pe_array_ctrl.sv
// Job sequencer for the NxN weight-stationary systolic PE array: preloads
// N*N weights from the weight buffer, streams input column vectors with the
// per-row skew, and tags each result on acc_out with acc_valid.
module pe_array_ctrl
  import pe_array_pkg::*;
#(
  parameter int PORT_WIDTH = DEF_PORT_WIDTH,
  parameter int N          = DEF_N,
  parameter int ACC_LAT    = DEF_ACC_LAT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  pe_array_ctrl_if.master  bus
);

  localparam int PE_W = pe_id_w(N);
  localparam logic [PE_W-1:0] LAST_ADDR = PE_W'(N * N - 1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_num_cols;
  logic [CNT_W-1:0]        r_col_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_w_rd_en;
  logic [PE_W-1:0]         r_w_rd_addr;
  logic                    r_wori;
  logic [PE_W-1:0]         r_wloc;
  logic                    r_x_ready;
  logic [ACC_LAT-1:0]      r_vpipe;

  logic                    w_xfer;
  logic                    w_last_col;
  logic                    w_last_addr;
  logic [N*PORT_WIDTH-1:0] w_a_out;

  assign w_xfer      = bus.x_valid & r_x_ready;
  assign w_last_col  = (r_col_cnt + CNT_W'(1)) == r_num_cols;
  assign w_last_addr = r_w_rd_addr == LAST_ADDR;

  // Job FSM: weight preload, drain of the last weight write, vector stream,
  // pipeline flush, and the done handshake back to the scheduler.
  // NOTE: all state and registered outputs use <= so every branch below sees
  // the values from the start of the cycle, never a half-updated mix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_num_cols  <= '0;
      r_col_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_rd_en   <= 1'b0;
      r_w_rd_addr <= '0;
      r_wori      <= 1'b0;
      r_wloc      <= '0;
      r_x_ready   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A start coinciding with the done pulse belongs to the old job.
          if (bus.start && !r_done) begin
            r_num_cols  <= bus.num_cols;
            r_col_cnt   <= '0;
            r_busy      <= 1'b1;
            r_w_rd_en   <= 1'b1;
            r_w_rd_addr <= '0;
            r_state     <= ST_WLOAD;
          end
        end

        ST_WLOAD: begin
          // Read data returns next cycle; tag it with the address it came from.
          r_wori <= 1'b1;
          r_wloc <= r_w_rd_addr;
          if (w_last_addr) begin
            r_w_rd_en <= 1'b0;
            r_state   <= ST_WDRAIN;
          end else begin
            r_w_rd_addr <= r_w_rd_addr + PE_W'(1);
          end
        end

        ST_WDRAIN: begin
          // Last weight lands on the array this cycle; streaming may follow.
          r_wori <= 1'b0;
          if (r_num_cols == '0) begin
            r_state <= ST_FLUSH;
          end else begin
            r_x_ready <= 1'b1;
            r_state   <= ST_STREAM;
          end
        end

        ST_STREAM: begin
          if (w_xfer) begin
            if (r_col_cnt != r_num_cols) r_col_cnt <= r_col_cnt + CNT_W'(1);
            if (w_last_col) begin
              r_x_ready <= 1'b0;
              r_state   <= ST_FLUSH;
            end
          end
        end

        ST_FLUSH: begin
          // Wait for the last tagged result to leave acc_out.
          if (r_vpipe == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Valid pipe: one bit per issued array cycle, 1 for a real vector, 0 for a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vpipe <= '0;
    else        r_vpipe <= {r_vpipe[ACC_LAT-2:0], w_xfer};
  end

  // Per-row skew: lane k is delayed k cycles; idle cycles feed zeros.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [PORT_WIDTH-1:0] w_lane_in;
    assign w_lane_in = w_xfer ? bus.x_data[k*PORT_WIDTH +: PORT_WIDTH] : '0;

    skew_delay_line #(
      .PORT_WIDTH (PORT_WIDTH),
      .DEPTH      (k)
    ) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (w_lane_in),
      .o_q   (w_a_out[k*PORT_WIDTH +: PORT_WIDTH])
    );
  end

  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.w_rd_en         = r_w_rd_en;
  assign bus.w_rd_addr       = r_w_rd_addr;
  assign bus.x_ready         = r_x_ready;
  assign bus.WorI            = r_wori;
  assign bus.weight_in       = r_wori ? bus.w_rd_data : '0;
  assign bus.weight_location = r_wloc;
  assign bus.a_out           = w_a_out;
  assign bus.acc_valid       = r_vpipe[ACC_LAT-1];

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl: weight preload, skew, back-pressure,
// empty jobs, start filtering and mid-job reset.
module tb_pe_array_ctrl;

  localparam int PW = 8;
  localparam int NN = 5;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  pe_array_ctrl_if #(.PORT_WIDTH(PW), .N(NN), .CNT_W(16)) bus ();

  pe_array_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight buffer model: registered read returning addr+1.
  always @(posedge clk) begin
    if (bus.w_rd_en) bus.w_rd_data <= 8'(bus.w_rd_addr) + 8'd1;
    else             bus.w_rd_data <= 8'd0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next active edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] cols);
    bus.num_cols = cols;
    bus.start    = 1'b1;
    cyc();
    bus.start    = 1'b0;
  endtask

  // Wait (bounded) for x_ready; returns cycles waited, 60 on timeout.
  task automatic wait_x_ready(output int n);
    n = 0;
    while (bus.x_ready !== 1'b1 && n < 60) begin
      cyc();
      n++;
    end
  endtask

  // Run a one-vector job to completion.
  task automatic run_one_job(input string tag);
    int n;
    int acc;
    bit got_done;
    start_job(16'd1);
    wait_x_ready(n);
    n_cmp++;
    if (n !== 26) begin n_bad++; $display("FAIL %s_ready_lat: got %0d expected 26", tag, n); end
    bus.x_valid = 1'b1;
    bus.x_data  = 40'h0A_0B_0C_0D_0E;
    cyc();
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    acc = 0;
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (bus.acc_valid === 1'b1) acc++;
      if (bus.done === 1'b1) got_done = 1'b1;
      else cyc();
    end
    n_cmp++;
    if (got_done !== 1'b1) begin n_bad++; $display("FAIL %s_done: got %0b expected 1", tag, got_done); end
    n_cmp++;
    if (acc !== 1) begin n_bad++; $display("FAIL %s_acc_cnt: got %0d expected 1", tag, acc); end
    cyc();
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.num_cols = '0;
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    repeat (2) cyc();
    n_cmp++;
    if ({bus.busy, bus.done, bus.w_rd_en, bus.WorI, bus.x_ready, bus.acc_valid} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.busy, bus.done, bus.w_rd_en, bus.WorI, bus.x_ready, bus.acc_valid});
    end
    n_cmp++;
    if ({bus.w_rd_addr, bus.weight_location, bus.weight_in} !== '0) begin
      n_bad++;
      $display("FAIL reset_wt: got %0h expected 0", {bus.w_rd_addr, bus.weight_location, bus.weight_in});
    end
    n_cmp++;
    if (bus.a_out !== '0) begin n_bad++; $display("FAIL reset_a_out: got %0h expected 0", bus.a_out); end
    rst_n = 1'b1;
    cyc();
  endtask

  // T1: 25 reads, then 25 weight writes with location/value in order.
  task automatic test_weight_load();
    int nw;
    logic exp_rd;
    logic exp_w;
    nw = 0;
    start_job(16'd0);
    for (int c = 0; c < 28; c++) begin
      exp_rd = (c < 25);
      exp_w  = (c >= 1 && c <= 25);
      n_cmp++;
      if (bus.w_rd_en !== exp_rd) begin n_bad++; $display("FAIL wl_rd_en c=%0d: got %0b expected %0b", c, bus.w_rd_en, exp_rd); end
      if (exp_rd) begin
        n_cmp++;
        if (bus.w_rd_addr !== 5'(c)) begin n_bad++; $display("FAIL wl_rd_addr c=%0d: got %0d expected %0d", c, bus.w_rd_addr, c); end
      end
      n_cmp++;
      if (bus.WorI !== exp_w) begin n_bad++; $display("FAIL wl_wori c=%0d: got %0b expected %0b", c, bus.WorI, exp_w); end
      if (bus.WorI === 1'b1) nw++;
      if (exp_w) begin
        n_cmp++;
        if (bus.weight_location !== 5'(c - 1)) begin n_bad++; $display("FAIL wl_loc c=%0d: got %0d expected %0d", c, bus.weight_location, c - 1); end
        n_cmp++;
        if (bus.weight_in !== 8'(c)) begin n_bad++; $display("FAIL wl_val c=%0d: got %0d expected %0d", c, bus.weight_in, c); end
      end
      cyc();
    end
    n_cmp++;
    if (nw !== 25) begin n_bad++; $display("FAIL wl_count: got %0d expected 25", nw); end
    repeat (2) cyc();
  endtask

  // T2: one vector; lane k appears k cycles later, acc_valid at ACC_LAT.
  task automatic test_skew();
    int n;
    logic [NN*PW-1:0] exp_a;
    start_job(16'd1);
    wait_x_ready(n);
    n_cmp++;
    if (n !== 26) begin n_bad++; $display("FAIL skew_ready_lat: got %0d expected 26", n); end
    bus.x_valid = 1'b1;
    bus.x_data  = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    for (int d = 0; d <= 16; d++) begin
      #1;
      exp_a = '0;
      if (d <= 4) exp_a[d*PW +: PW] = 8'(d + 1);
      n_cmp++;
      if (bus.a_out !== exp_a) begin n_bad++; $display("FAIL skew_a_out d=%0d: got %h expected %h", d, bus.a_out, exp_a); end
      n_cmp++;
      if (bus.acc_valid !== (d == 13)) begin n_bad++; $display("FAIL skew_acc_valid d=%0d: got %0b expected %0b", d, bus.acc_valid, d == 13); end
      n_cmp++;
      if (bus.done !== (d == 15)) begin n_bad++; $display("FAIL skew_done d=%0d: got %0b expected %0b", d, bus.done, d == 15); end
      if (d >= 1) begin
        n_cmp++;
        if (bus.x_ready !== 1'b0) begin n_bad++; $display("FAIL skew_x_ready d=%0d: got %0b expected 0", d, bus.x_ready); end
      end
      cyc();
      if (d == 0) begin
        bus.x_valid = 1'b0;
        bus.x_data  = '0;
      end
    end
  endtask

  // T3: bubbles in the input stream show up as gaps in acc_valid.
  task automatic test_back_pressure();
    int n;
    int acc;
    logic [6:0] pat;
    pat = 7'b1011001;  // bit p = x_valid in stream cycle p: 1,0,0,1,1,0,1
    acc = 0;
    start_job(16'd4);
    wait_x_ready(n);
    n_cmp++;
    if (n !== 26) begin n_bad++; $display("FAIL bp_ready_lat: got %0d expected 26", n); end
    for (int p = 0; p < 25; p++) begin
      bus.x_valid = (p < 7) ? pat[p] : 1'b0;
      bus.x_data  = {5{8'(p + 1)}};
      #1;
      n_cmp++;
      if (bus.x_ready !== (p < 7)) begin n_bad++; $display("FAIL bp_x_ready p=%0d: got %0b expected %0b", p, bus.x_ready, p < 7); end
      n_cmp++;
      if (bus.acc_valid !== (p == 13 || p == 16 || p == 17 || p == 19)) begin
        n_bad++;
        $display("FAIL bp_acc_valid p=%0d: got %0b", p, bus.acc_valid);
      end
      if (bus.acc_valid === 1'b1) acc++;
      n_cmp++;
      if (bus.done !== (p == 21)) begin n_bad++; $display("FAIL bp_done p=%0d: got %0b expected %0b", p, bus.done, p == 21); end
      cyc();
    end
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    n_cmp++;
    if (acc !== 4) begin n_bad++; $display("FAIL bp_acc_count: got %0d expected 4", acc); end
  endtask

  // T4: empty job finishes right after the weight load.
  task automatic test_zero_cols();
    start_job(16'd0);
    for (int c = 0; c < 30; c++) begin
      n_cmp++;
      if (bus.x_ready !== 1'b0 || bus.acc_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL zc_stream c=%0d: got x_ready=%0b acc_valid=%0b expected 0/0", c, bus.x_ready, bus.acc_valid);
      end
      n_cmp++;
      if (bus.done !== (c == 27)) begin n_bad++; $display("FAIL zc_done c=%0d: got %0b expected %0b", c, bus.done, c == 27); end
      n_cmp++;
      if (bus.busy !== (c < 27)) begin n_bad++; $display("FAIL zc_busy c=%0d: got %0b expected %0b", c, bus.busy, c < 27); end
      cyc();
    end
  endtask

  // T5: start mid-stream and start with done are ignored; start after done runs.
  task automatic test_start_while_busy();
    int n;
    int acc;
    acc = 0;
    start_job(16'd2);
    wait_x_ready(n);
    n_cmp++;
    if (n !== 26) begin n_bad++; $display("FAIL sb_ready_lat: got %0d expected 26", n); end
    for (int p = 0; p < 18; p++) begin
      bus.x_valid  = (p == 0 || p == 2);
      bus.x_data   = 40'h11_22_33_44_55;
      bus.start    = (p == 1 || p == 17);
      bus.num_cols = (p == 1) ? 16'd7 : 16'd9;
      #1;
      if (bus.acc_valid === 1'b1) acc++;
      if (p == 3) begin
        n_cmp++;
        if (bus.x_ready !== 1'b0) begin n_bad++; $display("FAIL sb_x_ready: got %0b expected 0", bus.x_ready); end
      end
      n_cmp++;
      if (bus.done !== (p == 17)) begin n_bad++; $display("FAIL sb_done p=%0d: got %0b expected %0b", p, bus.done, p == 17); end
      cyc();
    end
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    n_cmp++;
    if (acc !== 2) begin n_bad++; $display("FAIL sb_acc_count: got %0d expected 2", acc); end
    // Start asserted with done was dropped.
    n_cmp++;
    if ({bus.busy, bus.w_rd_en} !== 2'b00) begin n_bad++; $display("FAIL sb_start_at_done: got %b expected 00", {bus.busy, bus.w_rd_en}); end
    // Back-to-back start right after done.
    bus.start    = 1'b1;
    bus.num_cols = 16'd1;
    cyc();
    bus.start    = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.w_rd_en, bus.w_rd_addr} !== {2'b11, 5'd0}) begin
      n_bad++;
      $display("FAIL sb_restart: got %b expected 1100000", {bus.busy, bus.w_rd_en, bus.w_rd_addr});
    end
    wait_x_ready(n);
    n_cmp++;
    if (n !== 26) begin n_bad++; $display("FAIL sb_restart_ready: got %0d expected 26", n); end
    bus.x_valid = 1'b1;
    cyc();
    bus.x_valid = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    n_cmp++;
    if (n !== 14) begin n_bad++; $display("FAIL sb_restart_done: got %0d expected 14", n); end
    cyc();
  endtask

  // T6: reset after 2 of 6 accepts aborts cleanly; a new job then runs.
  task automatic test_reset_mid_stream();
    int n;
    start_job(16'd6);
    wait_x_ready(n);
    n_cmp++;
    if (n !== 26) begin n_bad++; $display("FAIL rm_ready_lat: got %0d expected 26", n); end
    bus.x_valid = 1'b1;
    bus.x_data  = 40'h99_88_77_66_55;
    repeat (2) cyc();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.w_rd_en, bus.WorI, bus.x_ready, bus.acc_valid} !== 6'b0) begin
      n_bad++;
      $display("FAIL rm_ctrl: got %b expected 000000",
               {bus.busy, bus.done, bus.w_rd_en, bus.WorI, bus.x_ready, bus.acc_valid});
    end
    n_cmp++;
    if (bus.a_out !== '0) begin n_bad++; $display("FAIL rm_a_out: got %h expected 0", bus.a_out); end
    cyc();
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if ({bus.busy, bus.done, bus.acc_valid} !== 3'b000) begin
        n_bad++;
        $display("FAIL rm_after c=%0d: got %b expected 000", c, {bus.busy, bus.done, bus.acc_valid});
      end
      cyc();
    end
    run_one_job("rm_new");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.start    = 1'b0;
    bus.num_cols = '0;
    bus.x_valid  = 1'b0;
    bus.x_data   = '0;
    test_reset();
    test_weight_load();
    test_skew();
    test_back_pressure();
    test_zero_cols();
    test_start_while_busy();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
